// File: rtl/load_ext_pkg.sv
// Shared size codes, FSM state encoding and the lane extension helper for the
// load sequencer.
package load_ext_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Lane arrives right-justified; widen it to 32 bits by sign or zero fill.
  function automatic logic [31:0] extend(input logic [31:0] lane, input logic [1:0] size,
                                         input logic sgn);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: res = {{16{sgn & lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_lane_extend.sv
// Combinational lane select and sign/zero extension of a little-endian read
// word.
module load_lane_extend
  import load_ext_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata;
    case (size)
      SZ_BYTE: lane = {24'b0, rdata[{off, 3'b000} +: 8]};
      SZ_HALF: lane = {16'b0, rdata[{off[1], 4'b0000} +: 16]};
      default: lane = rdata;
    endcase
  end

  assign data = extend(lane, size, sgn);

endmodule

// File: rtl/load_extend_ctrl.sv
// Multi-cycle load sequencer: one aligned read per request, lane extend, tagged
// response. Define MISALIGN_TRAP_EN to trap misaligned half/word loads.
module load_extend_ctrl
  import load_ext_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mem_rd_en,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             req_ready_q, req_ready_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      ext_data;
  logic             misalign;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  load_lane_extend u_lane (
    .rdata (mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .sgn   (sgn_q),
    .data  (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    tag_d      = tag_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          sgn_d  = req_signed;
          tag_d  = req_tag;
          if ((req_size == SZ_RSVD) || misalign) begin
            state_d    = ST_RESP;
            rsp_data_d = 32'b0;
            rsp_tag_d  = req_tag;
            rsp_err_d  = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Data arriving on the timeout cycle still wins over the error.
        if (mem_rvalid) begin
          state_d    = ST_RESP;
          rsp_data_d = ext_data;
          rsp_tag_d  = tag_q;
          rsp_err_d  = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d    = ST_RESP;
          rsp_data_d = 32'b0;
          rsp_tag_d  = tag_q;
          rsp_err_d  = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Control outputs are registered copies of the upcoming state.
    req_ready_d = (state_d == ST_IDLE);
    mem_rd_en_d = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      off_q       <= 2'b0;
      size_q      <= 2'b0;
      sgn_q       <= 1'b0;
      tag_q       <= '0;
      req_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      tag_q       <= tag_d;
      req_ready_q <= req_ready_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

endmodule
